mem_port_arbiter: RTL

- Shares the single memory-controller port (one read channel, one write channel) among NR core read requesters (instruction fetch, data load) and NW write requesters (store).
- Sits between the core request ports and the UART memory controller.
- Serialises all traffic: one outstanding transaction at a time, either read or write.
- Pending writes take priority over reads; round-robin arbitration within each class; a watchdog aborts hung transactions.

---
 rtl/mem_port_arbiter_pkg.sv | 22 ++
 rtl/mem_port_arbiter_rr_pick.sv | 29 ++
 rtl/mem_port_arbiter.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_RD   = 2'd1,
        ARB_WR   = 2'd2,
        ARB_ACK  = 2'd3
    } arb_state_e;

    // Access-length codes carried through to the memory controller.
    localparam logic [1:0] LEN_CODE_B = 2'd0;
    localparam logic [1:0] LEN_CODE_H = 2'd1;
    localparam logic [1:0] LEN_CODE_W = 2'd2;

    localparam int unsigned DEFAULT_TIMEOUT = 1023;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after i_ptr, wrapping mod N.
module mem_port_arbiter_rr_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = idx_w(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] w_c;

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        w_c     = '0;
        for (int k = 0; k < int'(N); k++) begin
            w_c = IW'((int'(i_ptr) + k) % int'(N));
            if (!o_valid && i_req[w_c]) begin
                o_valid = 1'b1;
                o_idx   = w_c;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises NR read and NW write requesters onto one memory-controller port.
// Writes beat reads, round robin within each class, watchdog aborts hung transfers.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NR      = 2,
    parameter int unsigned NW      = 1,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned LEN_W   = 2,
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NR-1:0]          r_req,
    input  logic [NR*ADDR_W-1:0]   r_addr,
    input  logic [NR*LEN_W-1:0]    r_len,
    output logic [NR*DATA_W-1:0]   r_data,
    output logic [NR-1:0]          r_ack,
    input  logic [NW-1:0]          w_req,
    input  logic [NW*ADDR_W-1:0]   w_addr,
    input  logic [NW*LEN_W-1:0]    w_len,
    input  logic [NW*DATA_W-1:0]   w_data,
    output logic [NW-1:0]          w_ack,
    output logic                   m_re,
    output logic [ADDR_W-1:0]      m_raddr,
    output logic [LEN_W-1:0]       m_rlen,
    input  logic [DATA_W-1:0]      m_din,
    input  logic                   m_rack,
    output logic                   m_we,
    output logic [ADDR_W-1:0]      m_waddr,
    output logic [LEN_W-1:0]       m_wlen,
    output logic [DATA_W-1:0]      m_dout,
    input  logic                   m_wack,
    output logic                   busy,
    output logic                   tmo_err
);

    localparam int unsigned IWR = idx_w(NR);
    localparam int unsigned IWW = idx_w(NW);
    localparam int unsigned GW  = idx_w((NR > NW) ? NR : NW);
    localparam int unsigned CW  = idx_w(TIMEOUT + 1);

    arb_state_e        r_state, w_state_d;
    logic              r_is_wr, r_tmo;
    logic [GW-1:0]     r_gnt;
    logic [IWR-1:0]    r_rptr, w_ridx;
    logic [IWW-1:0]    r_wptr, w_widx;
    logic              w_rvalid, w_wvalid;
    logic [ADDR_W-1:0] r_maddr, w_rd_addr, w_wr_addr;
    logic [LEN_W-1:0]  r_mlen, w_rd_len, w_wr_len;
    logic [DATA_W-1:0] r_mdata, w_wr_data;
    logic [CW-1:0]     r_cnt;
    logic              w_tmo_hit, w_rgrant, w_wgrant, w_tmo;

    mem_port_arbiter_rr_pick #(.N(NR), .IW(IWR)) u_rd_pick (
        .i_req   (r_req),
        .i_ptr   (r_rptr),
        .o_valid (w_rvalid),
        .o_idx   (w_ridx)
    );

    mem_port_arbiter_rr_pick #(.N(NW), .IW(IWW)) u_wr_pick (
        .i_req   (w_req),
        .i_ptr   (r_wptr),
        .o_valid (w_wvalid),
        .o_idx   (w_widx)
    );

    always_comb begin
        w_rd_addr = '0;
        w_rd_len  = '0;
        for (int i = 0; i < int'(NR); i++) begin
            if (w_ridx == IWR'(i)) begin
                w_rd_addr = r_addr[i*ADDR_W +: ADDR_W];
                w_rd_len  = r_len[i*LEN_W +: LEN_W];
            end
        end
    end

    always_comb begin
        w_wr_addr = '0;
        w_wr_len  = '0;
        w_wr_data = '0;
        for (int i = 0; i < int'(NW); i++) begin
            if (w_widx == IWW'(i)) begin
                w_wr_addr = w_addr[i*ADDR_W +: ADDR_W];
                w_wr_len  = w_len[i*LEN_W +: LEN_W];
                w_wr_data = w_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // r_cnt counts completed cycles in RD/WR; this is the last one allowed.
    assign w_tmo_hit = (TIMEOUT != 0) && (32'(r_cnt) == TIMEOUT - 1);

    always_comb begin
        w_state_d = r_state;
        w_rgrant  = 1'b0;
        w_wgrant  = 1'b0;
        w_tmo     = 1'b0;
        unique case (r_state)
            ARB_IDLE: begin
                if (w_wvalid) begin
                    w_wgrant  = 1'b1;
                    w_state_d = ARB_WR;
                end else if (w_rvalid) begin
                    w_rgrant  = 1'b1;
                    w_state_d = ARB_RD;
                end
            end
            ARB_RD: begin
                if (m_rack) begin
                    w_state_d = ARB_ACK;
                end else if (w_tmo_hit) begin
                    w_tmo     = 1'b1;
                    w_state_d = ARB_ACK;
                end
            end
            ARB_WR: begin
                if (m_wack) begin
                    w_state_d = ARB_ACK;
                end else if (w_tmo_hit) begin
                    w_tmo     = 1'b1;
                    w_state_d = ARB_ACK;
                end
            end
            ARB_ACK:  w_state_d = ARB_IDLE;
            default:  w_state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ARB_IDLE;
            r_is_wr <= 1'b0;
            r_tmo   <= 1'b0;
            r_gnt   <= '0;
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_maddr <= '0;
            r_mlen  <= '0;
            r_mdata <= '0;
            r_cnt   <= '0;
            r_data  <= '0;
        end else begin
            r_state <= w_state_d;
            r_tmo   <= w_tmo;
            if (r_state == ARB_RD || r_state == ARB_WR) begin
                r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_wgrant) begin
                r_is_wr <= 1'b1;
                r_gnt   <= GW'(w_widx);
                r_maddr <= w_wr_addr;
                r_mlen  <= w_wr_len;
                r_mdata <= w_wr_data;
                r_wptr  <= (int'(w_widx) == int'(NW) - 1) ? '0 : w_widx + IWW'(1);
            end
            if (w_rgrant) begin
                r_is_wr <= 1'b0;
                r_gnt   <= GW'(w_ridx);
                r_maddr <= w_rd_addr;
                r_mlen  <= w_rd_len;
                r_rptr  <= (int'(w_ridx) == int'(NR) - 1) ? '0 : w_ridx + IWR'(1);
            end
            // An aborted read returns zero data to its requester.
            if (r_state == ARB_RD && (m_rack || w_tmo_hit)) begin
                for (int i = 0; i < int'(NR); i++) begin
                    if (r_gnt == GW'(i)) begin
                        r_data[i*DATA_W +: DATA_W] <= m_rack ? m_din : '0;
                    end
                end
            end
        end
    end

    always_comb begin
        r_ack = '0;
        for (int i = 0; i < int'(NR); i++) begin
            r_ack[i] = (r_state == ARB_ACK) && !r_is_wr && (r_gnt == GW'(i));
        end
    end

    always_comb begin
        w_ack = '0;
        for (int i = 0; i < int'(NW); i++) begin
            w_ack[i] = (r_state == ARB_ACK) && r_is_wr && (r_gnt == GW'(i));
        end
    end

    assign m_re    = (r_state == ARB_RD);
    assign m_we    = (r_state == ARB_WR);
    assign m_raddr = r_maddr;
    assign m_rlen  = r_mlen;
    assign m_waddr = r_maddr;
    assign m_wlen  = r_mlen;
    assign m_dout  = r_mdata;
    assign busy    = (r_state != ARB_IDLE);
    assign tmo_err = (r_state == ARB_ACK) && r_tmo;

endmodule
